nvdla_csb_seq: RTL
==================

Name: nvdla_csb_seq

Overview:
- Parametrised CSB command sequencer; successor to the single-transaction HWPE control FSM.
- Buffers a queue of CSB commands (read / write / wait-for-interrupt) and executes them back-to-back after one start.
- Streams read data out and supervises every wait with a programmable timeout.
- Sits between the HWPE slave/regfile and the NVDLA CSB master port.

Parameters:
- ADDR_W, 16, CSB address width
- DATA_W, 32, CSB data width
- DEPTH, 8, command FIFO entries (power of 2, >=2)
- N_INTR, 2, number of interrupt lines
- TIMEOUT_W, 16, timeout counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command push valid
- cmd_ready_o  out  1  FIFO not full
- cmd_op_i  in  2  00 read, 01 write, 10 wait_intr, 11 poll/illegal
- cmd_addr_i  in  ADDR_W  CSB address
- cmd_wdata_i  in  DATA_W  write data (poll: mask)
- cmd_intr_mask_i  in  N_INTR  lines accepted by wait_intr
- start_i  in  1  start execution pulse
- timeout_cycles_i  in  TIMEOUT_W  wait limit; 0 disables the timeout
- busy_o  out  1  sequence running
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky abort flag, cleared by the next accepted start
- csb_req_valid_o  out  1  CSB request valid
- csb_req_ready_i  in  1  CSB request accepted
- csb_req_addr_o  out  ADDR_W  request address
- csb_req_wdata_o  out  DATA_W  request data
- csb_req_write_o  out  1  1 = write
- csb_rd_valid_i  in  1  read response valid
- csb_rd_data_i  in  DATA_W  read response data
- csb_wr_complete_i  in  1  write complete pulse
- intr_i  in  N_INTR  NVDLA interrupt levels
- rdata_valid_o  out  1  read result valid
- rdata_ready_i  in  1  read result accepted
- rdata_o  out  DATA_W  read result

Behaviour:
- Reset: FIFO empty, state IDLE, timeout counter 0.
  - All outputs 0 except cmd_ready_o, which is 1 (derived as ~full).
- FIFO:
  - Push on cmd_valid_i & cmd_ready_o.
  - Pop when ISSUE completes a handshake, or when WAIT_INTR is entered.
  - Push when full is refused (no bypass).
  - Simultaneous push+pop when not full: count unchanged.
  - Pushes are allowed while busy; they are executed in the same run.
- States: IDLE, ISSUE, WAIT_RSP, WAIT_INTR, PUSH_RD, FINISH.
- IDLE:
  - start_i with FIFO non-empty -> ISSUE next cycle; busy_o=1; error_o cleared.
  - start_i with FIFO empty -> FINISH; done_o pulses on the following cycle; error_o cleared.
  - start_i while not in IDLE is ignored.
- ISSUE, head op read or write:
  - csb_req_valid_o=1; addr, wdata and write are taken from the FIFO head.
  - These outputs are held stable until csb_req_ready_i.
  - On handshake: pop -> WAIT_RSP. The op and the poll mask are latched.
- ISSUE, head op wait_intr: pop; latch the mask -> WAIT_INTR. No CSB request is issued.
- WAIT_RSP:
  - Read: csb_rd_valid_i -> capture data -> PUSH_RD.
  - Write: csb_wr_complete_i -> NEXT.
  - Responses in any other state, or of the wrong type, are ignored.
- WAIT_INTR:
  - Level-sensitive on |(intr_i & mask) -> NEXT.
  - If the condition is already true on entry, exit after 1 cycle.
- PUSH_RD:
  - rdata_valid_o=1; rdata_o held stable until rdata_ready_i -> NEXT.
  - No timeout applies in PUSH_RD.
- NEXT: FIFO non-empty -> ISSUE; else -> FINISH.
- FINISH: done_o=1 for exactly one cycle; busy_o=0 -> IDLE.
- Timeout:
  - Counter resets on entry to WAIT_RSP or WAIT_INTR and increments each cycle spent there.
  - When timeout_cycles_i!=0 and counter==timeout_cycles_i-1 without the exit condition: abort.
  - Abort: flush FIFO, error_o=1 -> FINISH.
  - The exit condition arriving in the same cycle as the timeout wins; no error.
- Illegal op (11 without the macro): abort as above, same cycle as ISSUE. No CSB request is issued.
- rst_i mid-operation returns to the reset state in the next cycle and drops any pending request. The CSB master must tolerate this.
- Latency, single read with immediate ready/response/rdata_ready:
  - start -> req_valid: 1 cycle.
  - rd_valid -> rdata_valid_o: 1 cycle.
  - Last NEXT -> done_o: 1 cycle.

Optional Feature:
- Macro: NVDLA_CSB_SEQ_POLL_EN
- Defined: op 11 = poll.
  - Issue a read; in WAIT_RSP compare (rd_data & mask)==mask.
  - Match -> NEXT; no push to rdata.
  - Mismatch -> ISSUE again with the same latched addr/mask.
  - The timeout counter spans the whole poll: it resets only on first issue.
- Undefined: op 11 is illegal and aborts with error_o=1. No compare logic is instantiated.

Test Plan:
- Push write(0x0010, 0xDEADBEEF), read(0x0014); start; response 0xCAFE0001 -> one write req, one read req, rdata_o=0xCAFE0001, done_o one pulse, error_o=0.
- Fill FIFO with 8 commands -> cmd_ready_o=0; a 9th push is refused; start -> all 8 issued in order; cmd_ready_o=1 after the first pop.
- wait_intr mask=2'b10: intr_i=2'b01 for 50 cycles, then 2'b10 -> exit 1 cycle after 2'b10; intr_i=2'b01 is ignored.
- timeout_cycles_i=20, read with no response -> abort after 20 cycles in WAIT_RSP; FIFO flushed; error_o=1, done_o pulse; next start clears error_o.
- rdata_ready_i low for 10 cycles -> rdata_valid_o/rdata_o stable throughout; no further CSB request is issued.
- POLL_EN: poll mask 0x4, reads 0x0, 0x0, 0x4 -> 3 requests, no rdata_valid_o, done_o. Without macro: op 11 -> error_o=1, zero requests.

Source files
------------

// File: rtl/nvdla_csb_seq.sv
// CSB command sequencer: queues read/write/wait-for-interrupt commands and runs them back-to-back.
// Define NVDLA_CSB_SEQ_POLL_EN to turn op 2'b11 into a masked poll; otherwise op 2'b11 aborts.
module nvdla_csb_seq #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int N_INTR    = 2,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [1:0]           cmd_op_i,
   input  logic [ADDR_W-1:0]    cmd_addr_i,
   input  logic [DATA_W-1:0]    cmd_wdata_i,
   input  logic [N_INTR-1:0]    cmd_intr_mask_i,
   input  logic                 start_i,
   input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic                 csb_req_valid_o,
   input  logic                 csb_req_ready_i,
   output logic [ADDR_W-1:0]    csb_req_addr_o,
   output logic [DATA_W-1:0]    csb_req_wdata_o,
   output logic                 csb_req_write_o,
   input  logic                 csb_rd_valid_i,
   input  logic [DATA_W-1:0]    csb_rd_data_i,
   input  logic                 csb_wr_complete_i,
   input  logic [N_INTR-1:0]    intr_i,
   output logic                 rdata_valid_o,
   input  logic                 rdata_ready_i,
   output logic [DATA_W-1:0]    rdata_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_WAIT = 2'b10;
   localparam logic [1:0] OP_POLL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_RSP  = 3'd2,
      ST_WAIT_INTR = 3'd3,
      ST_PUSH_RD   = 3'd4,
      ST_FINISH    = 3'd5
   } state_e;

   logic [1:0]        op_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [N_INTR-1:0] mask_mem [DEPTH];

   logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]     count_r;
   state_e               state_r;
   logic                 req_valid_r, req_write_r, rdata_valid_r;
   logic                 busy_r, done_r, error_r, repoll_r;
   logic [ADDR_W-1:0]    req_addr_r;
   logic [DATA_W-1:0]    req_wdata_r, rdata_r;
   logic [1:0]           op_r;
   logic [N_INTR-1:0]    intr_mask_r;
   logic [TIMEOUT_W-1:0] tmr_r;

   logic full_s, empty_s, push_s, pop_s, next_s, exit_s, abort_s, tmo_hit_s;
   logic head_req_s, poll_match_s;
   logic [1:0]        head_op_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic [DATA_W-1:0] head_data_s;
   logic [N_INTR-1:0] head_mask_s;

   assign full_s      = (count_r == CNT_W'(DEPTH));
   assign empty_s     = (count_r == CNT_W'(0));
   assign push_s      = cmd_valid_i & ~full_s;
   assign head_op_s   = op_mem[rd_ptr_r];
   assign head_addr_s = addr_mem[rd_ptr_r];
   assign head_data_s = data_mem[rd_ptr_r];
   assign head_mask_s = mask_mem[rd_ptr_r];

`ifdef NVDLA_CSB_SEQ_POLL_EN
   logic [DATA_W-1:0] poll_mask_r;
   assign head_req_s   = (head_op_s != OP_WAIT);
   assign poll_match_s = csb_rd_valid_i & ((csb_rd_data_i & poll_mask_r) == poll_mask_r);
`else
   assign head_req_s   = (head_op_s == OP_RD) | (head_op_s == OP_WR);
   assign poll_match_s = 1'b0;
`endif

   // Per-state pop / advance / abort decisions shared by the FIFO and the FSM
   always_comb begin
      pop_s     = 1'b0;
      next_s    = 1'b0;
      exit_s    = 1'b0;
      abort_s   = 1'b0;
      tmo_hit_s = (timeout_cycles_i != TIMEOUT_W'(0)) &&
                  (tmr_r == timeout_cycles_i - TIMEOUT_W'(1));
      case (state_r)
         ST_IDLE: next_s = start_i;
         ST_ISSUE: begin
            if (req_valid_r) begin
               pop_s = csb_req_ready_i & ~repoll_r;
            end else if (head_op_s == OP_WAIT) begin
               pop_s = 1'b1;
            end else begin
               abort_s = 1'b1;
            end
         end
         ST_WAIT_RSP: begin
            if (op_r == OP_WR) begin
               exit_s = csb_wr_complete_i;
            end else if (op_r == OP_RD) begin
               exit_s = csb_rd_valid_i;
            end else begin
               exit_s = poll_match_s;
            end
            next_s  = exit_s & (op_r != OP_RD);
            abort_s = tmo_hit_s & ~exit_s;
         end
         ST_WAIT_INTR: begin
            exit_s  = |(intr_i & intr_mask_r);
            next_s  = exit_s;
            abort_s = tmo_hit_s & ~exit_s;
         end
         ST_PUSH_RD: next_s = rdata_ready_i;
         default: next_s = 1'b0;
      endcase
   end

   // Command storage; contents need no reset because validity lives in count_r
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         op_mem[wr_ptr_r]   <= cmd_op_i;
         addr_mem[wr_ptr_r] <= cmd_addr_i;
         data_mem[wr_ptr_r] <= cmd_wdata_i;
         mask_mem[wr_ptr_r] <= cmd_intr_mask_i;
      end
   end

   // FIFO pointers; an abort flushes everything except a push landing in the same cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else if (abort_s) begin
         wr_ptr_r <= wr_ptr_r + PTR_W'(push_s);
         rd_ptr_r <= wr_ptr_r;
         count_r  <= CNT_W'(push_s);
      end else begin
         wr_ptr_r <= wr_ptr_r + PTR_W'(push_s);
         rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
         count_r  <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // Sequencer FSM with registered outputs; later assignments (advance, abort) take priority
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r       <= ST_IDLE;
         req_valid_r   <= 1'b0;
         req_write_r   <= 1'b0;
         req_addr_r    <= ADDR_W'(0);
         req_wdata_r   <= DATA_W'(0);
         op_r          <= OP_RD;
         intr_mask_r   <= N_INTR'(0);
         tmr_r         <= TIMEOUT_W'(0);
         rdata_r       <= DATA_W'(0);
         rdata_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         error_r       <= 1'b0;
         repoll_r      <= 1'b0;
`ifdef NVDLA_CSB_SEQ_POLL_EN
         poll_mask_r   <= DATA_W'(0);
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: if (start_i) error_r <= 1'b0;
            ST_ISSUE: begin
               if (req_valid_r) begin
                  if (csb_req_ready_i) begin
                     req_valid_r <= 1'b0;
                     state_r     <= ST_WAIT_RSP;
                     if (!repoll_r) tmr_r <= TIMEOUT_W'(0);
                  end
               end else if (head_op_s == OP_WAIT) begin
                  intr_mask_r <= head_mask_s;
                  tmr_r       <= TIMEOUT_W'(0);
                  state_r     <= ST_WAIT_INTR;
               end
            end
            ST_WAIT_RSP: begin
               tmr_r <= tmr_r + TIMEOUT_W'(1);
               if (op_r == OP_RD && csb_rd_valid_i) begin
                  rdata_r       <= csb_rd_data_i;
                  rdata_valid_r <= 1'b1;
                  state_r       <= ST_PUSH_RD;
               end
`ifdef NVDLA_CSB_SEQ_POLL_EN
               else if (op_r == OP_POLL && csb_rd_valid_i && !poll_match_s) begin
                  req_valid_r <= 1'b1;
                  repoll_r    <= 1'b1;
                  state_r     <= ST_ISSUE;
               end
`endif
            end
            ST_WAIT_INTR: tmr_r <= tmr_r + TIMEOUT_W'(1);
            ST_PUSH_RD: if (rdata_ready_i) rdata_valid_r <= 1'b0;
            ST_FINISH: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
         if (next_s) begin
            if (!empty_s) begin
               state_r     <= ST_ISSUE;
               busy_r      <= 1'b1;
               req_valid_r <= head_req_s;
               req_addr_r  <= head_addr_s;
               req_wdata_r <= head_data_s;
               req_write_r <= (head_op_s == OP_WR);
               op_r        <= head_op_s;
               repoll_r    <= 1'b0;
`ifdef NVDLA_CSB_SEQ_POLL_EN
               poll_mask_r <= head_data_s;
`endif
            end else begin
               state_r <= ST_FINISH;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
            end
         end
         if (abort_s) begin
            state_r     <= ST_FINISH;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            error_r     <= 1'b1;
            req_valid_r <= 1'b0;
         end
      end
   end

   assign cmd_ready_o     = ~full_s;
   assign busy_o          = busy_r;
   assign done_o          = done_r;
   assign error_o         = error_r;
   assign csb_req_valid_o = req_valid_r;
   assign csb_req_addr_o  = req_addr_r;
   assign csb_req_wdata_o = req_wdata_r;
   assign csb_req_write_o = req_write_r;
   assign rdata_valid_o   = rdata_valid_r;
   assign rdata_o         = rdata_r;

endmodule
